// File: rtl/cpu_div_pkg.sv
// rtl/cpu_div_pkg.sv - shared constants and state encoding for the iterative divider
package cpu_div_pkg;

  localparam int DW    = 32;
  localparam int CNT_W = 6;

  localparam logic [DW-1:0] DIV0_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    RUN  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_t;

endpackage

// File: rtl/iter_divider_if.sv
// rtl/iter_divider_if.sv - request/response bundle between controller and divider
interface iter_divider_if;
  import cpu_div_pkg::*;

  logic          start;
  logic          is_signed;
  logic [DW-1:0] dividend;
  logic [DW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [DW-1:0] remainder;
  logic          div_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_zero
  );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring division step: shift in a dividend bit, trial subtract
module div_step
  import cpu_div_pkg::*;
(
  input  logic [DW-1:0] r,
  input  logic          a_msb,
  input  logic [DW-1:0] abs_b,
  output logic [DW-1:0] r_next,
  output logic          q_bit
);

  logic [DW:0]   r_shift;
  logic [DW-1:0] diff;

  assign r_shift = {r, a_msb};
  // Low bits of the 33-bit difference are exact whenever the subtract is taken.
  assign diff    = r_shift[DW-1:0] - abs_b;
  assign q_bit   = (r_shift >= {1'b0, abs_b});
  assign r_next  = q_bit ? diff : r_shift[DW-1:0];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle signed/unsigned restoring divider with leading-zero skip
module iter_divider
  import cpu_div_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  iter_divider_if.slave div,
  output logic [DW-1:0] clz_data,
  input  logic [31:0]   lz_count
);

  div_state_t       state;
  logic             sign_q;
  logic             sign_r;
  logic [DW-1:0]    abs_b;
  logic [DW-1:0]    dividend_q;
  logic [DW-1:0]    a_reg;
  logic [DW-1:0]    r_reg;
  logic [DW-1:0]    q_reg;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] lz;
  logic             busy_r;
  logic             done_r;
  logic             div_zero_r;
  logic [DW-1:0]    quotient_r;
  logic [DW-1:0]    remainder_r;
  logic [DW-1:0]    a_abs;
  logic [DW-1:0]    b_abs;
  logic [DW-1:0]    step_r;
  logic             step_q;

  assign a_abs = (div.is_signed && div.dividend[DW-1]) ? -div.dividend : div.dividend;
  assign b_abs = (div.is_signed && div.divisor[DW-1])  ? -div.divisor  : div.divisor;
  assign lz    = (lz_count > 32'(DW)) ? CNT_W'(DW) : lz_count[CNT_W-1:0];

  div_step u_step (
    .r      (r_reg),
    .a_msb  (a_reg[DW-1]),
    .abs_b  (abs_b),
    .r_next (step_r),
    .q_bit  (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      abs_b       <= '0;
      dividend_q  <= '0;
      clz_data    <= '0;
      a_reg       <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      count       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      div_zero_r  <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (div.start) begin
            sign_q     <= div.is_signed & (div.dividend[DW-1] ^ div.divisor[DW-1]);
            sign_r     <= div.is_signed & div.dividend[DW-1];
            abs_b      <= b_abs;
            dividend_q <= div.dividend;
            clz_data   <= a_abs;
            div_zero_r <= 1'b0;
            busy_r     <= 1'b1;
            state      <= PREP;
          end
        end
        PREP: begin
          if (abs_b == '0) begin
            q_reg      <= DIV0_QUOT;
            r_reg      <= dividend_q;
            div_zero_r <= 1'b1;
            state      <= FIX;
          end else if (lz == CNT_W'(DW)) begin
            q_reg <= '0;
            r_reg <= '0;
            state <= FIX;
          end else begin
            // Skip the leading-zero iterations: they would only shift in zero quotient bits.
            a_reg <= clz_data << lz;
            r_reg <= '0;
            q_reg <= '0;
            count <= CNT_W'(DW) - lz;
            state <= RUN;
          end
        end
        RUN: begin
          r_reg <= step_r;
          q_reg <= {q_reg[DW-2:0], step_q};
          a_reg <= {a_reg[DW-2:0], 1'b0};
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (div_zero_r) begin
            quotient_r  <= q_reg;
            remainder_r <= r_reg;
          end else begin
            quotient_r  <= sign_q ? -q_reg : q_reg;
            remainder_r <= sign_r ? -r_reg : r_reg;
          end
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign div.busy      = busy_r;
  assign div.done      = done_r;
  assign div.div_zero  = div_zero_r;
  assign div.quotient  = quotient_r;
  assign div.remainder = remainder_r;

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - scoreboard bench for iter_divider with an external Clz model
module tb_iter_divider;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    int          c0;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] clz_data;
  logic [31:0] lz_count;
  int          cycle_cnt;
  int          busy_cycles;
  int          checks;
  int          failures;
  exp_t        exp_q[$];

  iter_divider_if dif();

  iter_divider dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div      (dif),
    .clz_data (clz_data),
    .lz_count (lz_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  function automatic logic [31:0] clz_fn(input logic [31:0] x);
    logic [31:0] n;
    n = 32;
    for (int i = 0; i < 32; i++) begin
      if (x[i]) n = 32'(31 - i);
    end
    return n;
  endfunction

  always_comb lz_count = clz_fn(clz_data);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] mag;
    int          bits;
    int          sa;
    int          sb;
    e.dz = 1'b0;
    if (b == 0) begin
      e.q  = 32'hFFFF_FFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (!sg) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 0;
    end else begin
      sa  = $signed(a);
      sb  = $signed(b);
      e.q = 32'(sa / sb);
      e.r = 32'(sa % sb);
    end
    mag  = (sg && a[31]) ? -a : a;
    bits = 0;
    while (mag != 0) begin
      bits++;
      mag = mag >> 1;
    end
    e.lat = (b == 0 || bits == 0) ? 3 : 3 + bits;
    e.c0  = 0;
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_cycles = 0;
    end else begin
      if (dif.busy) busy_cycles++;
      if (dif.done) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done: got done=1 expected no result pending");
        end else begin
          e = exp_q.pop_front();
          chk("quotient", dif.quotient, e.q);
          chk("remainder", dif.remainder, e.r);
          chk("div_zero", 32'(dif.div_zero), 32'(e.dz));
          chk("latency", 32'(cycle_cnt - e.c0), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cycles), 32'(e.lat - 1));
          chk("busy_at_done", 32'(dif.busy), 32'd0);
        end
        busy_cycles = 0;
      end
    end
  end

  task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [31:0] mag;
    @(negedge clk);
    e    = model(sg, a, b);
    e.c0 = cycle_cnt;
    exp_q.push_back(e);
    dif.start     = 1'b1;
    dif.is_signed = sg;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk);
    #1 dif.start = 1'b0;
    @(negedge clk);
    mag = (sg && a[31]) ? -a : a;
    chk("clz_data_prep", clz_data, mag);
    if (mag == 0) chk("lz_count_prep", lz_count, 32'd32);
  endtask

  task automatic wait_done(input bit poke);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (poke && i == 1) begin
        dif.start    = 1'b1;
        dif.dividend = 32'd99;
        dif.divisor  = 32'd3;
      end
      if (poke && i == 2) dif.start = 1'b0;
      if (dif.done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
    if (poke) dif.start = 1'b1;
    @(posedge clk);
    #1 dif.start = 1'b0;
  endtask

  task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b, input bit poke);
    issue(sg, a, b);
    wait_done(poke);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks        = 0;
    failures      = 0;
    cycle_cnt     = 0;
    busy_cycles   = 0;
    rst_n         = 1'b0;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(dif.busy), 32'd0);
    chk("rst_done", 32'(dif.done), 32'd0);
    chk("rst_quotient", dif.quotient, 32'd0);
    chk("rst_remainder", dif.remainder, 32'd0);
    chk("rst_div_zero", 32'(dif.div_zero), 32'd0);
    chk("rst_clz_data", clz_data, 32'd0);
    rst_n = 1'b1;

    run_op(1'b0, 32'd7, 32'd2, 1'b0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0);
    run_op(1'b1, 32'h1234_5678, 32'd0, 1'b0);
    run_op(1'b1, 32'hF234_5678, 32'd0, 1'b0);
    run_op(1'b0, 32'd0, 32'd5, 1'b0);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'($urandom_range(1, 15));
        1: b = (n % 7 == 0) ? 32'd0 : b >> $urandom_range(0, 31);
        2: a = a >> $urandom_range(0, 31);
        default: ;
      endcase
      run_op(1'($urandom_range(0, 1)), a, b, 1'b0);
    end

    issue(1'b0, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(dif.busy), 32'd0);
    chk("abort_done", 32'(dif.done), 32'd0);
    chk("abort_quotient", dif.quotient, 32'd0);
    chk("abort_remainder", dif.remainder, 32'd0);
    chk("abort_div_zero", 32'(dif.div_zero), 32'd0);
    chk("abort_clz_data", clz_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, 1'b1);

    repeat (40) @(negedge clk);
    chk("pending_results", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
Name: iter_divider

Overview:
- Multi-cycle signed/unsigned 32-bit restoring divider for the DIV/DIVU path of the 54-instruction CPU.
- Writes quotient to LO and remainder to HI.
- Sits directly downstream of the Clz unit:
  - drives Clz with the absolute dividend;
  - consumes Clz's leading-zero count to skip leading iterations.
- Uses a start/busy/done handshake to stall the pipeline/controller until results are valid.

Parameters:
- DW, 32, operand/result width; only 32 is supported.
- CNT_W, 6, width of the iteration counter; must hold 0..DW.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a divide; sampled only in IDLE.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU.
- dividend  input  32  rs operand.
- divisor  input  32  rt operand.
- clz_data  output  32  registered absolute dividend, fed to the Clz unit's data input.
- lz_count  input  32  Clz result for clz_data; combinational return, valid during PREP.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse; results valid from this cycle onward.
- quotient  output  32  to LO; held until next accepted start.
- remainder  output  32  to HI; held until next accepted start.
- div_zero  output  1  divisor was zero; held with results.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. busy, done, div_zero = 0. quotient, remainder, clz_data = 0. Internal regs cleared. Reset mid-operation aborts the divide and discards it.
- States: IDLE, PREP, RUN, FIX, DONE.
- IDLE, start=1 (cycle T):
  - latch sign_q = is_signed & (dividend[31] ^ divisor[31]);
  - latch sign_r = is_signed & dividend[31];
  - latch abs_a, abs_b (negate when is_signed and MSB set);
  - clz_data <= abs_a; busy <= 1; done <= 0;
  - go PREP.
  - start while not IDLE is ignored.
- PREP (T+1):
  - lz = min(lz_count, 32).
  - If abs_b == 0: quotient_raw = 0xFFFFFFFF, remainder_raw = dividend (raw, unsigned), div_zero <= 1; go FIX, sign fix disabled.
  - Else if lz == 32 (dividend 0): quotient_raw = 0, remainder_raw = 0; go FIX.
  - Else: shift register A = abs_a << lz; partial remainder R = 0; count = 32 - lz; go RUN.
- RUN: one restoring step per cycle (div_step):
  - R' = {R[30:0], A[31]};
  - if R' >= abs_b then R = R' - abs_b, q bit 1; else R = R', q bit 0;
  - A shifts left, q bit shifts in at LSB; count decrements;
  - count reaching 0 -> FIX.
  - RUN lasts exactly N = 32 - lz cycles.
- FIX (one cycle):
  - quotient <= sign_q ? -Q : Q; remainder <= sign_r ? -R : R;
  - the div-zero path bypasses negation;
  - go DONE.
- DONE (one cycle): done=1, busy=0; go IDLE. A start in DONE is ignored; accepted next cycle in IDLE.
- Latency: done high in cycle T+3+N. Divide-by-zero and zero dividend give T+3. Worst case (lz=0) is T+35.
- Arithmetic: all intermediate values unsigned 32-bit, 33-bit compare/subtract. Signed -2^31 / -1 wraps to quotient 0x80000000, remainder 0, with no exception. Remainder sign follows dividend, matching the MIPS convention.

Decomposition:
- Package cpu_div_pkg:
  - state enum (IDLE, PREP, RUN, FIX, DONE);
  - DW, CNT_W constants;
  - DIV0_QUOT = 32'hFFFFFFFF.
- One combinational sub-module, div_step: inputs R, A-MSB, abs_b; outputs next R and q bit.
- Clz stays external and is wired via clz_data/lz_count at the top level.

Test Plan:
- Unsigned 7/2 (start at T) -> busy T+1..T+5, done at T+6, quotient=3, remainder=1, div_zero=0.
- Signed 0xFFFFFFF9/2 (-7/2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Unsigned same operands -> quotient=0x7FFFFFFC, remainder=1, done at T+35.
- 0x12345678/0 (either mode) -> done at T+3, quotient=0xFFFFFFFF, remainder=0x12345678, div_zero=1.
- 0/5 -> done at T+3, quotient=0, remainder=0; check clz_data=0 during PREP and lz_count=32 consumed.
- Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, done at T+35.
- Assert rst_n=0 at T+4 of a 35-cycle divide -> all outputs 0 immediately. Re-issue 100/7 after release -> quotient=14, remainder=2. A second start pulsed while busy is ignored.
